// File: rtl/qr_input_buffer.sv
// Ping-pong RE capture buffer feeding the QR core one column per beat.
// Optional build macro: QRIB_STATS_EN adds the o_re_cnt delivered-RE counter.
module qr_input_buffer #(
  parameter int DW         = 48,
  parameter int RE_PER_GRP = 10
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_trig,
  input  logic [DW-1:0]   i_data,
  input  logic            i_rdy,
  output logic            o_vld,
  output logic [4*DW-1:0] o_col,
  output logic [2:0]      o_col_idx,
  output logic            o_re_last,
  output logic            o_grp_last,
`ifdef QRIB_STATS_EN
  output logic [15:0]     o_re_cnt,
`endif
  output logic            o_ovf
);

  localparam int GW = (RE_PER_GRP > 1) ? $clog2(RE_PER_GRP) : 1;
  localparam logic [GW-1:0] GRP_MAX = GW'(RE_PER_GRP - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [4:0]  wcnt;
  logic        wsel;
  logic        rsel;
  logic [1:0]  full;
  logic [1:0]  full_nxt;
  logic [2:0]  bcnt;
  logic [GW-1:0] grp_cnt;

  logic [DW-1:0] mem [0:39];

  logic       free_now;
  logic       wr_ok;
  logic       wr_last;
  logic [5:0] waddr;

  assign free_now = (state == SEND) && i_rdy && (bcnt == 3'd4);
  // The buffer being released this cycle may take a new word immediately.
  assign wr_ok    = i_trig && (!full[wsel] || (free_now && (rsel == wsel)));
  assign wr_last  = wr_ok && (wcnt == 5'd19);
  assign waddr    = {1'b0, wcnt} + (wsel ? 6'd20 : 6'd0);

  always_comb begin
    full_nxt = full;
    if (free_now) full_nxt[rsel] = 1'b0;
    if (wr_last)  full_nxt[wsel] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[waddr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wcnt  <= '0;
      wsel  <= 1'b0;
      full  <= '0;
      o_ovf <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_ok) begin
        if (wcnt == 5'd19) begin
          wcnt <= '0;
          wsel <= ~wsel;
        end else begin
          wcnt <= wcnt + 5'd1;
        end
      end
      if (i_trig && !wr_ok) o_ovf <= 1'b1;
    end
  end

  // Reader looks at next-cycle full flags so o_vld rises right after word 19.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      bcnt     <= '0;
      rsel     <= 1'b0;
      grp_cnt  <= '0;
`ifdef QRIB_STATS_EN
      o_re_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bcnt <= '0;
          if (full_nxt[rsel]) state <= SEND;
        end
        SEND: begin
          if (i_rdy) begin
            if (bcnt == 3'd4) begin
              bcnt    <= '0;
              rsel    <= ~rsel;
              grp_cnt <= (grp_cnt == GRP_MAX) ? '0 : grp_cnt + GW'(1);
`ifdef QRIB_STATS_EN
              o_re_cnt <= o_re_cnt + 16'd1;
`endif
              if (!full_nxt[~rsel]) state <= IDLE;
            end else begin
              bcnt <= bcnt + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_vld      = (state == SEND);
  assign o_col_idx  = bcnt;
  assign o_re_last  = o_vld && (bcnt == 3'd4);
  assign o_grp_last = o_vld && (grp_cnt == GRP_MAX);

  // Column c of an RE is words 4c..4c+3; the y vector (c=4) fits the same rule.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
      logic [5:0] raddr;
      assign raddr = (rsel ? 6'd20 : 6'd0) + {1'b0, bcnt, 2'b00} + 6'(gi);
      assign o_col[gi*DW +: DW] = o_vld ? mem[raddr] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_qr_input_buffer.sv
// Directed, table-driven bench for qr_input_buffer.
module tb_qr_input_buffer;
  localparam int DW = 48;
  localparam int CW = 4 * DW;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_trig = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_rdy = 1'b0;
  logic          o_vld;
  logic [CW-1:0] o_col;
  logic [2:0]    o_col_idx;
  logic          o_re_last;
  logic          o_grp_last;
  logic          o_ovf;
`ifdef QRIB_STATS_EN
  logic [15:0]   o_re_cnt;
`endif

  qr_input_buffer #(.DW(DW), .RE_PER_GRP(10)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_trig(i_trig), .i_data(i_data), .i_rdy(i_rdy),
    .o_vld(o_vld), .o_col(o_col), .o_col_idx(o_col_idx), .o_re_last(o_re_last),
    .o_grp_last(o_grp_last),
`ifdef QRIB_STATS_EN
    .o_re_cnt(o_re_cnt),
`endif
    .o_ovf(o_ovf)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0]    idx;
    logic [CW-1:0] col;
    logic          last;
    logic          grp;
  } beat_t;

  typedef struct {
    bit         trig;
    int         data;
    bit         rdy;
    bit         exp_vld;
    logic [2:0] exp_idx;
    int         exp_base;
    bit         exp_last;
  } vec_t;

  beat_t beats[$];
  vec_t  vt[25];
  int    checks = 0;
  int    failures = 0;
  int    exp_base[16];

  function automatic logic [CW-1:0] col4(int base);
    logic [CW-1:0] r;
    r = {DW'(base + 3), DW'(base + 2), DW'(base + 1), DW'(base)};
    return r;
  endfunction

  task automatic chk(string name, logic [CW-1:0] act, logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, log a beat the DUT will hand over, return 1 after posedge.
  task automatic tick(bit trig, int data, bit rdy);
    beat_t b;
    @(negedge i_clk);
    i_trig = trig;
    i_data = DW'(data);
    i_rdy  = rdy;
    if (o_vld && i_rdy) begin
      b.idx = o_col_idx; b.col = o_col; b.last = o_re_last; b.grp = o_grp_last;
      beats.push_back(b);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1; i_trig = 1'b0; i_rdy = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    beats.delete();
  endtask

  task automatic check_stream(string tag, int n_re);
    int r, c;
    chk($sformatf("%s nbeats", tag), CW'(beats.size()), CW'(n_re * 5));
    for (int b = 0; b < beats.size() && b < n_re * 5; b++) begin
      r = b / 5;
      c = b % 5;
      chk($sformatf("%s b%0d idx", tag, b), CW'(beats[b].idx), CW'(c));
      chk($sformatf("%s b%0d col", tag, b), beats[b].col, col4(exp_base[r] + 4 * c));
      chk($sformatf("%s b%0d re_last", tag, b), CW'(beats[b].last), CW'(c == 4));
      chk($sformatf("%s b%0d grp_last", tag, b), CW'(beats[b].grp), CW'(r == 9));
    end
  endtask

  initial begin
    for (int k = 0; k < 20; k++) vt[k] = '{1'b1, k + 1, 1'b1, (k == 19), 3'd0, 1, 1'b0};
    for (int k = 20; k < 25; k++)
      vt[k] = '{1'b0, 0, 1'b1, (k < 24), 3'(k - 19), 1 + 4 * (k - 19), (k == 23)};

    // Reset state
    #2 i_rst = 1'b1;
    @(negedge i_clk);
    chk("rst vld", CW'(o_vld), '0);
    chk("rst col", o_col, '0);
    chk("rst idx", CW'(o_col_idx), '0);
    chk("rst re_last", CW'(o_re_last), '0);
    chk("rst grp_last", CW'(o_grp_last), '0);
    chk("rst ovf", CW'(o_ovf), '0);
`ifdef QRIB_STATS_EN
    chk("rst re_cnt", CW'(o_re_cnt), '0);
`endif
    i_rst = 1'b0;

    // One RE, cycle-accurate table
    for (int i = 0; i < 25; i++) begin
      tick(vt[i].trig, vt[i].data, vt[i].rdy);
      chk($sformatf("t1 v%0d vld", i), CW'(o_vld), CW'(vt[i].exp_vld));
      if (vt[i].exp_vld) begin
        chk($sformatf("t1 v%0d idx", i), CW'(o_col_idx), CW'(vt[i].exp_idx));
        chk($sformatf("t1 v%0d col", i), o_col, col4(vt[i].exp_base));
        chk($sformatf("t1 v%0d re_last", i), CW'(o_re_last), CW'(vt[i].exp_last));
      end
    end

    // Ten-RE group, continuous input
    do_reset();
    for (int k = 0; k < 200; k++) tick(1'b1, k + 1, 1'b1);
    for (int k = 0; k < 10; k++) tick(1'b0, 0, 1'b1);
    for (int r = 0; r < 10; r++) exp_base[r] = r * 20 + 1;
    check_stream("grp", 10);
    chk("grp ovf", CW'(o_ovf), '0);
`ifdef QRIB_STATS_EN
    chk("grp re_cnt", CW'(o_re_cnt), CW'(10));
`endif

    // Backpressure on beat 2
    do_reset();
    for (int k = 0; k < 20; k++) tick(1'b1, k + 1, 1'b1);
    tick(1'b0, 0, 1'b1);
    tick(1'b0, 0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      tick(1'b0, 0, 1'b0);
      chk($sformatf("bp c%0d vld", k), CW'(o_vld), CW'(1));
      chk($sformatf("bp c%0d idx", k), CW'(o_col_idx), CW'(2));
      chk($sformatf("bp c%0d col", k), o_col, col4(9));
    end
    tick(1'b0, 0, 1'b1);
    chk("bp resume idx", CW'(o_col_idx), CW'(3));
    for (int k = 0; k < 3; k++) tick(1'b0, 0, 1'b1);
    exp_base[0] = 1;
    check_stream("bp", 1);

    // Overflow with the core stalled
    do_reset();
    for (int k = 0; k < 40; k++) tick(1'b1, k + 1, 1'b0);
    chk("ovf before drop", CW'(o_ovf), '0);
    tick(1'b1, 41, 1'b0);
    chk("ovf after drop", CW'(o_ovf), CW'(1));
    for (int k = 0; k < 12; k++) tick(1'b0, 0, 1'b1);
    exp_base[0] = 1; exp_base[1] = 21;
    check_stream("ovf", 2);
    chk("ovf sticky", CW'(o_ovf), CW'(1));
    beats.delete();
    for (int k = 0; k < 20; k++) tick(1'b1, 101 + k, 1'b1);
    for (int k = 0; k < 8; k++) tick(1'b0, 0, 1'b1);
    exp_base[0] = 101;
    check_stream("ovf next", 1);

    // Word arriving on the cycle that frees a buffer
    do_reset();
    for (int k = 0; k < 40; k++) tick(1'b1, k + 1, 1'b0);
    for (int k = 0; k < 4; k++) tick(1'b0, 0, 1'b1);
    for (int k = 0; k < 20; k++) tick(1'b1, 501 + k, 1'b1);
    for (int k = 0; k < 8; k++) tick(1'b0, 0, 1'b1);
    exp_base[0] = 1; exp_base[1] = 21; exp_base[2] = 501;
    check_stream("sim", 3);
    chk("sim ovf", CW'(o_ovf), '0);

    // Asynchronous reset mid-delivery with a partial second RE
    do_reset();
    for (int k = 0; k < 20; k++) tick(1'b1, k + 1, 1'b1);
    tick(1'b1, 201, 1'b1);
    tick(1'b1, 202, 1'b1);
    chk("mrst pre idx", CW'(o_col_idx), CW'(2));
    i_rst = 1'b1;
    #1;
    chk("mrst vld", CW'(o_vld), '0);
    chk("mrst col", o_col, '0);
    chk("mrst idx", CW'(o_col_idx), '0);
    chk("mrst re_last", CW'(o_re_last), '0);
    chk("mrst grp_last", CW'(o_grp_last), '0);
    @(negedge i_clk);
    i_rst = 1'b0; i_trig = 1'b0;
    beats.delete();
    for (int k = 0; k < 20; k++) tick(1'b1, 301 + k, 1'b1);
    for (int k = 0; k < 8; k++) tick(1'b0, 0, 1'b1);
    exp_base[0] = 301;
    check_stream("mrst", 1);
    chk("mrst ovf", CW'(o_ovf), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qr_input_buffer.md
# qr_input_buffer

Upstream front end of `QR_Engine`. It captures the serial `i_trig`/`i_data` stream (20 × 48-bit words per resource element, RE) into a two-entry ping-pong RE buffer. It then presents each complete RE to the QR core one column per beat over a valid/ready handshake. It decouples the fixed-rate input stream from the variable-latency decomposition and flags any lost input.

## Interface
Parameters:
- `DW`, 48: width of one complex word (imag [47:24], real [23:0]); passed through untouched.
- `RE_PER_GRP`, 10: REs per group; sets `o_grp_last`.

Ports:
- `i_clk`  in  1  single clock; all logic on the rising edge.
- `i_rst`  in  1  reset, asynchronous and active-high.
- `i_trig`  in  1  `i_data` valid this cycle.
- `i_data`  in  DW  input word.
- `i_rdy`  in  1  QR core accepts the current beat.
- `o_vld`  out  1  beat valid.
- `o_col`  out  4*DW  beat payload, row 0 in [DW-1:0] up to row 3 in [4*DW-1:3*DW].
- `o_col_idx`  out  3  0–3 = H columns 0–3, 4 = y vector.
- `o_re_last`  out  1  last beat of an RE (`o_col_idx`==4).
- `o_grp_last`  out  1  beat belongs to the last RE of a group.
- `o_ovf`  out  1  sticky: at least one input word was dropped.
- `o_re_cnt`  out  16  REs fully delivered; present only with `QRIB_STATS_EN`.

## Operation
Input word order within an RE:
- Words 0–15 hold H, column-major. Word k → column k/4, row k%4.
- Words 16–19 hold y rows 0–3.

Writer:
- Word counter `wcnt` runs 0–19 and a write pointer `wsel` selects buffer 0 or 1.
- Each cycle with `i_trig`=1 and the selected buffer not full, the word is stored at `wcnt` and `wcnt` increments.
- At `wcnt`==19 the buffer's full flag is set, `wcnt` returns to 0 and `wsel` toggles.
- A low `i_trig` simply holds state; a partial RE waits indefinitely.

Reader FSM:
- IDLE: move to SEND when the buffer at read pointer `rsel` is full.
- SEND: beat counter `bcnt` runs 0–4. `o_col` = column `bcnt` of buffer `rsel`, `o_col_idx`=`bcnt`.
- Each `o_vld`&`i_rdy` increments `bcnt`.
- On acceptance of beat 4:
  - clear that buffer's full flag, toggle `rsel`, reset `bcnt`;
  - advance the group counter, which counts 0 to RE_PER_GRP−1 and wraps;
  - stay in SEND if the other buffer is full, otherwise go to IDLE.
- `o_grp_last` = (group counter == RE_PER_GRP−1) during SEND.
- The payload is held stable while `o_vld`=1 and `i_rdy`=0.

Overflow and simultaneous events:
- Both buffers full and `i_trig`=1 → the word is dropped, `o_ovf` is set and stays set until reset. Counters do not move.
- Beat 4 accepted in the same cycle as an `i_trig` word while both buffers are full → the word is accepted. It goes into the buffer being freed, which is always the one `wsel` points to.
- `i_rst` asserted mid-RE or mid-delivery discards all buffered data immediately.

## Timing
- Reset values:
  - `o_vld`=0, `o_col`=0, `o_col_idx`=0, `o_re_last`=0, `o_grp_last`=0, `o_ovf`=0, `o_re_cnt`=0.
  - Internally `wcnt`=0, `wsel`=`rsel`=0, both full flags 0, FSM in IDLE, group counter 0.
- Latency: `o_vld` rises in the cycle after the edge that captures word 19.
- Throughput:
  - With `i_rdy` held high, one RE takes 5 output cycles, back to back across buffers, with no bubble between REs.
  - Input sustains 1 word/cycle with no drops as long as the core averages ≤20 cycles per RE.
- `o_*` outputs are registered or decoded directly from registered state; there are no combinational paths from `i_trig`/`i_data`/`i_rdy` to outputs.

## Configuration
- `QRIB_STATS_EN` defined:
  - `o_re_cnt` is present and increments on each beat-4 acceptance.
  - It wraps from 0xFFFF to 0 and resets to 0.
- Not defined: the port and counter are removed. All other behaviour is identical.

## Test plan
- Reset then one RE:
  - Stimulus: words = k+1 for k=0..19, `i_rdy`=1.
  - Required: `o_vld` rises 1 cycle after word 19.
  - Beats: `o_col_idx` 0..4; beat 0 `o_col` = {4,3,2,1}, beat 4 = {20,19,18,17}.
  - `o_re_last` is high only on beat 4.
- Ten-RE group:
  - Stimulus: 200 continuous words, `i_rdy`=1.
  - Required: 50 beats, `o_grp_last`=1 only for beats 45–49, `o_ovf`=0, `o_re_cnt`=10.
- Backpressure:
  - Stimulus: `i_rdy`=0 for 7 cycles during beat 2.
  - Required: `o_col` and `o_col_idx`=2 stay stable; delivery resumes with beat 3.
- Overflow:
  - Stimulus: `i_rdy`=0 throughout, 41 words.
  - Required: both buffers full after word 40 (word indices 0..39 stored); word 41 is dropped and `o_ovf`=1.
  - Then `i_rdy`=1: exactly 2 REs are delivered with the original data.
- Simultaneous free/write:
  - Stimulus: both buffers full, beat 4 accepted in the same cycle as `i_trig`.
  - Required: the word is stored as word 0 of the freed buffer and `o_ovf` stays 0.
- Reset mid-operation:
  - Stimulus: assert `i_rst` during beat 2 with a partial second RE buffered.
  - Required: outputs go to reset values asynchronously; the next 20 words form a clean RE delivered from buffer 0.
